pc_seq: RTL and testbench

Parametrised program-counter sequencer for the custom CPU fetch stage. It is the next generation of the PC/PC_LUT pair: one block holding the program counter, a runtime-writable jump-target table, signed relative branches, stall and halt control, and an optional return-address stack for call/return. Its output drives the instruction-memory address; the control decoder drives its inputs.

---
 rtl/pc_seq.sv | 166 ++++++++++++++++
 tb/tb_pc_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with jump table, relative branch, halt and optional return stack
// Optional feature macro: PC_RAS_EN (builds the SD-entry return-address stack for call/return)
// Ports:
//   clk, reset (asynchronous, active-low)
//   stall, halt_req, absjump_en, reljump_en, call_en, ret_en : flow control requests
//   lut_idx (LW) table read index, offset (D) signed relative offset
//   lut_we, lut_waddr (LW), lut_wdata (D) : jump-table write port
//   prog_ctr (D) current PC, halted, stk_err (sticky stack over/underflow)
module pc_seq #(
    parameter int D  = 12,
    parameter int LW = 5,
    parameter int SD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          halt_req,
    input  logic          absjump_en,
    input  logic          reljump_en,
    input  logic          call_en,
    input  logic          ret_en,
    input  logic [LW-1:0] lut_idx,
    input  logic [D-1:0]  offset,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic          halted,
    output logic          stk_err
);

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [D-1:0]   lut_q [2**LW];
    logic [D-1:0]   lut_rd;
    logic [D-1:0]   pc_inc;
    logic           advance;

    // Combinational table read sees the pre-write contents on a same-cycle write.
    assign lut_rd  = lut_q[lut_idx];
    assign pc_inc  = pc_q + 1'b1;
    // Flow requests act only in RUN, when not halting this edge and not stalled.
    assign advance = (state_q == S_RUN) && !halt_req && !stall;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: HALT is sticky until reset
    always_comb begin
        state_d = state_q;
        if (state_q == S_RUN && halt_req) begin
            state_d = S_HALT;
        end
    end

    // FSM outputs
    always_comb begin
        halted = (state_q == S_HALT);
    end

`ifdef PC_RAS_EN
    localparam int AW  = (SD > 1) ? $clog2(SD) : 1;
    localparam int SPW = $clog2(SD + 1);

    logic [D-1:0]   stk_q [SD];
    logic [SPW-1:0] sp_q, sp_d, sp_m1;
    logic           err_q, err_d;
    logic           push;
    logic           stk_full, stk_empty;

    // sp_q counts occupied entries; the top of stack lives at sp_q-1.
    assign sp_m1     = sp_q - 1'b1;
    assign stk_full  = (sp_q == SPW'(SD));
    assign stk_empty = (sp_q == '0);
    assign stk_err   = err_q;
`else
    logic unused_cfg;

    assign unused_cfg = ret_en | (SD < 2);
    assign stk_err    = 1'b0;
`endif

    // Next-PC selection, highest priority first.
    always_comb begin
        pc_d = pc_q;
`ifdef PC_RAS_EN
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
`endif
        if (advance) begin
`ifdef PC_RAS_EN
            if (ret_en) begin
                if (!stk_empty) begin
                    pc_d = stk_q[sp_m1[AW-1:0]];
                    sp_d = sp_m1;
                end else begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end else if (call_en) begin
                // The jump is always taken; only the push is dropped on overflow.
                pc_d = lut_rd;
                if (!stk_full) begin
                    push = 1'b1;
                    sp_d = sp_q + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else
`endif
            if (absjump_en || call_en) begin
                pc_d = lut_rd;
            end else if (reljump_en) begin
                pc_d = pc_q + offset;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // PC and jump table; table writes are honoured in HALT as well.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            for (int i = 0; i < 2**LW; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (lut_we) begin
                lut_q[lut_waddr] <= lut_wdata;
            end
        end
    end

`ifdef PC_RAS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack payload needs no reset: emptiness is tracked by sp_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            stk_q[sp_q[AW-1:0]] <= pc_inc;
        end
    end
`endif

    assign prog_ctr = pc_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq: vector table, directed sequences, random vs reference model
module tb_pc_seq;

    localparam int D  = 12;
    localparam int LW = 5;
    localparam int SD = 4;
    localparam int M  = 4096;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0, halt_req = 1'b0, absjump_en = 1'b0, reljump_en = 1'b0;
    logic          call_en = 1'b0, ret_en = 1'b0, lut_we = 1'b0;
    logic [LW-1:0] lut_idx = '0, lut_waddr = '0;
    logic [D-1:0]  offset = '0, lut_wdata = '0;
    logic [D-1:0]  prog_ctr;
    logic          halted, stk_err;

    always #5 clk = ~clk;

    pc_seq #(.D(D), .LW(LW), .SD(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .halt_req   (halt_req),
        .absjump_en (absjump_en),
        .reljump_en (reljump_en),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .lut_idx    (lut_idx),
        .offset     (offset),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .prog_ctr   (prog_ctr),
        .halted     (halted),
        .stk_err    (stk_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_pc;
    bit m_halt, m_err;
    int m_tab [32];
    int m_stk [$];

    typedef struct {
        bit st, hq, ab, rl, cl, rt;
        int idx, off;
        bit we;
        int wa, wd;
        int exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_in();
        stall = 0; halt_req = 0; absjump_en = 0; reljump_en = 0;
        call_en = 0; ret_en = 0; lut_we = 0;
        lut_idx = '0; lut_waddr = '0; offset = '0; lut_wdata = '0;
    endtask

    // One clock edge of the specified behaviour, evaluated from the current inputs.
    task automatic model_edge();
        int tgt;
        int off;
        if (!m_halt) begin
            if (halt_req) begin
                m_halt = 1;
            end else if (!stall) begin
                tgt = m_tab[lut_idx];
                off = int'($signed(offset));
                if (RAS && ret_en) begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_pc = (m_pc + 1) % M; m_err = 1; end
                end else if (call_en) begin
                    if (RAS) begin
                        if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) % M);
                        else m_err = 1;
                    end
                    m_pc = tgt;
                end else if (absjump_en) begin
                    m_pc = tgt;
                end else if (reljump_en) begin
                    m_pc = ((m_pc + off) % M + M) % M;
                end else begin
                    m_pc = (m_pc + 1) % M;
                end
            end
        end
        if (lut_we) m_tab[lut_waddr] = lut_wdata;
    endtask

    task automatic step(input string name);
        model_edge();
        @(posedge clk);
        #1;
        chk({name, " pc"}, int'(prog_ctr), m_pc);
        chk({name, " halted"}, int'(halted), int'(m_halt));
        chk({name, " stk_err"}, int'(stk_err), int'(m_err));
    endtask

    task automatic idle(input int n, input string name);
        clear_in();
        repeat (n) step(name);
    endtask

    task automatic do_reset();
        clear_in();
        reset = 0;
        #1;
        m_pc = 0; m_halt = 0; m_err = 0; m_stk.delete();
        for (int i = 0; i < 32; i++) m_tab[i] = 0;
        chk("reset pc", int'(prog_ctr), 0);
        chk("reset halted", int'(halted), 0);
        chk("reset stk_err", int'(stk_err), 0);
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic wr(input int idx, input int val);
        clear_in();
        lut_we = 1; lut_waddr = LW'(idx); lut_wdata = D'(val);
        step("wr");
    endtask

    task automatic jump(input int idx);
        clear_in();
        absjump_en = 1; lut_idx = LW'(idx);
        step("jump");
    endtask

    task automatic rel(input int off);
        clear_in();
        reljump_en = 1; offset = D'(off);
        step("rel");
    endtask

    task automatic call(input int idx);
        clear_in();
        call_en = 1; lut_idx = LW'(idx);
        step("call");
    endtask

    task automatic ret();
        clear_in();
        ret_en = 1;
        step("ret");
    endtask

    initial begin
        //        st hq ab rl cl rt idx  off we  wa   wd   exp
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,    0, 1, 18, 102,    1};
        vecs[1]  = '{0, 0, 1, 0, 0, 0, 18,   0, 0, 0,  0,    102};
        vecs[2]  = '{0, 0, 0, 1, 0, 0, 0,   -5, 0, 0,  0,     97};
        vecs[3]  = '{0, 0, 0, 1, 0, 0, 0,    3, 0, 0,  0,    100};
        vecs[4]  = '{1, 0, 1, 0, 0, 0, 18,   0, 0, 0,  0,    100};
        vecs[5]  = '{0, 0, 1, 1, 0, 0, 18,  50, 0, 0,  0,    102};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,    0, 1, 0,  7,    103};
        vecs[7]  = '{0, 0, 1, 0, 0, 0, 0,    0, 1, 0,  55,     7};
        vecs[8]  = '{0, 0, 1, 0, 0, 0, 0,    0, 0, 0,  0,     55};
        vecs[9]  = '{0, 0, 0, 1, 0, 0, 0, -100, 0, 0,  0,   4051};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0,    0, 0, 0,  0,   4052};

        // Reset and free-running count, then an asynchronous reset mid-count
        do_reset();
        idle(10, "count");
        chk("count10", int'(prog_ctr), 10);
        idle(3, "count");
        #2;
        do_reset();

        // Vector table from a fresh reset (PC 0)
        for (int i = 0; i < 11; i++) begin
            stall = vecs[i].st; halt_req = vecs[i].hq;
            absjump_en = vecs[i].ab; reljump_en = vecs[i].rl;
            call_en = vecs[i].cl; ret_en = vecs[i].rt;
            lut_idx = LW'(vecs[i].idx); offset = D'(vecs[i].off);
            lut_we = vecs[i].we; lut_waddr = LW'(vecs[i].wa); lut_wdata = D'(vecs[i].wd);
            step("vec");
            chk($sformatf("vec%0d", i), int'(prog_ctr), vecs[i].exp);
        end

        // Table jump followed by counting
        jump(18);
        idle(10, "after jump");
        chk("jump+10", int'(prog_ctr), 112);

        // Wrap in both directions
        wr(1, 4094);
        jump(1);
        rel(3);
        chk("wrap fwd", int'(prog_ctr), 1);
        jump(1);
        idle(1, "wrap");
        chk("at 4095", int'(prog_ctr), 4095);
        idle(1, "wrap");
        chk("wrap inc", int'(prog_ctr), 0);
        wr(2, 20);
        jump(2);
        rel(-5);
        chk("rel back", int'(prog_ctr), 15);

        // Call / return
        do_reset();
        wr(0, 7); wr(3, 30);
        wr(4, 100); wr(5, 200); wr(6, 300); wr(7, 400);
        jump(3);
        call(0);
        chk("call", int'(prog_ctr), 7);
        idle(3, "in call");
        chk("call+3", int'(prog_ctr), 10);
        ret();
`ifdef PC_RAS_EN
        chk("ret", int'(prog_ctr), 31);
`else
        chk("ret ignored", int'(prog_ctr), 11);
`endif
        for (int k = 4; k < 8; k++) call(k);
        chk("nest top", int'(prog_ctr), 400);
        ret(); ret(); ret(); ret();
        chk("nest err", int'(stk_err), 0);
`ifdef PC_RAS_EN
        chk("nest unwound", int'(prog_ctr), 32);
        call(4);
        clear_in();
        ret_en = 1; call_en = 1; lut_idx = 5;
        step("ret+call");
        chk("ret+call pop", int'(prog_ctr), 33);
        for (int k = 4; k < 8; k++) call(k);
        call(4);
        chk("overflow jump", int'(prog_ctr), 100);
        chk("overflow err", int'(stk_err), 1);
        ret();
        chk("ovf top kept", int'(prog_ctr), 301);
        ret(); ret(); ret();
        chk("ovf bottom", int'(prog_ctr), 34);
        ret();
        chk("underflow pc", int'(prog_ctr), 35);
        chk("underflow err", int'(stk_err), 1);
`endif

        // Halt
        do_reset();
        wr(8, 40);
        jump(8);
        clear_in();
        halt_req = 1;
        absjump_en = 1; lut_idx = 0;
        step("halt");
        chk("halt pc", int'(prog_ctr), 40);
        chk("halt flag", int'(halted), 1);
        for (int k = 0; k < 5; k++) begin
            clear_in();
            absjump_en = k[0]; call_en = ~k[0]; reljump_en = 1; offset = 12'd9;
            lut_idx = 8; lut_we = 1; lut_waddr = 9; lut_wdata = D'(k);
            step("halted req");
            chk("halted pc", int'(prog_ctr), 40);
        end
        do_reset();
        clear_in();
        halt_req = 1; stall = 1;
        step("halt in stall");
        chk("halt stall flag", int'(halted), 1);

        // Randomised stimulus against the reference model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                stall      = ($urandom_range(0, 7) == 0);
                halt_req   = ($urandom_range(0, 199) == 0);
                absjump_en = $urandom_range(0, 1);
                reljump_en = $urandom_range(0, 1);
                call_en    = ($urandom_range(0, 3) == 0);
                ret_en     = ($urandom_range(0, 3) == 0);
                lut_idx    = LW'($urandom_range(0, 7));
                offset     = D'($urandom);
                lut_we     = $urandom_range(0, 1);
                lut_waddr  = LW'($urandom_range(0, 7));
                lut_wdata  = D'($urandom);
                step("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
